// File: rtl/alu_issue_if.sv
// alu_issue_if: handshake and data bundle between the ID stage, the ALU issue
// register and the EX stage. The slave modport is the issue stage's view and
// the master modport is the view of whatever drives ID and consumes EX.
interface alu_issue_if #(
  parameter int DATA_W = 32
);
  logic              flush;
  logic              id_valid;
  logic              id_ready;
  logic [31:0]       id_instr;
  logic [DATA_W-1:0] id_rs_data;
  logic [DATA_W-1:0] id_rt_data;
  logic              ex_valid;
  logic              ex_ready;
  logic [3:0]        ex_alu_ctrl;
  logic [4:0]        ex_shamt;
  logic [DATA_W-1:0] ex_src_a;
  logic [DATA_W-1:0] ex_src_b;
  logic              ex_ovf_chk;
  logic              ex_illegal;

  modport slave (
    input  flush, id_valid, id_instr, id_rs_data, id_rt_data, ex_ready,
    output id_ready, ex_valid, ex_alu_ctrl, ex_shamt, ex_src_a, ex_src_b,
           ex_ovf_chk, ex_illegal
  );

  modport master (
    output flush, id_valid, id_instr, id_rs_data, id_rt_data, ex_ready,
    input  id_ready, ex_valid, ex_alu_ctrl, ex_shamt, ex_src_a, ex_src_b,
           ex_ovf_chk, ex_illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes a MIPS instruction into ALU control, shift amount
// and operands, and holds the result in a main register plus one skid
// register so that id_ready comes straight from a flop.
// Optional feature macro: ALU_ISSUE_SHIFTV_EN (adds sllv/srlv decode).
module alu_issue_stage #(
  parameter int DATA_W    = 32,
  parameter int LUI_SHAMT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_issue_if.slave bus
);

  typedef struct packed {
    logic [3:0]        alu_ctrl;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              ovf_chk;
    logic              illegal;
  } entry_t;

  logic [5:0]        op;
  logic [5:0]        funct;
  logic [15:0]       imm;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;
  entry_t            dec;
  entry_t            main_reg;
  entry_t            skid_reg;
  logic              main_valid_reg;
  logic              skid_valid_reg;
  logic              accept;
  logic              drain;
  logic              load_main;

  assign op       = bus.id_instr[31:26];
  assign funct    = bus.id_instr[5:0];
  assign imm      = bus.id_instr[15:0];
  assign imm_sext = {{(DATA_W-16){imm[15]}}, imm};
  assign imm_zext = {{(DATA_W-16){1'b0}}, imm};

  // Combinational decode of the instruction currently presented by ID.
  always_comb begin
    dec         = '0;
    dec.src_a   = bus.id_rs_data;
    dec.src_b   = bus.id_rt_data;
    case (op)
      6'h00: begin
        case (funct)
          6'h20: begin dec.alu_ctrl = 4'b0000; dec.ovf_chk = 1'b1; end
          6'h21: dec.alu_ctrl = 4'b0000;
          6'h22: begin dec.alu_ctrl = 4'b0001; dec.ovf_chk = 1'b1; end
          6'h23: dec.alu_ctrl = 4'b0001;
          6'h24: dec.alu_ctrl = 4'b0010;
          6'h25: dec.alu_ctrl = 4'b0011;
          6'h26: dec.alu_ctrl = 4'b0100;
          6'h27: dec.alu_ctrl = 4'b0101;
          6'h2A: dec.alu_ctrl = 4'b0110;
          6'h2B: dec.alu_ctrl = 4'b0111;
          6'h00: begin dec.alu_ctrl = 4'b1001; dec.shamt = bus.id_instr[10:6]; end
          6'h02: begin dec.alu_ctrl = 4'b1000; dec.shamt = bus.id_instr[10:6]; end
`ifdef ALU_ISSUE_SHIFTV_EN
          6'h04: begin dec.alu_ctrl = 4'b1001; dec.shamt = bus.id_rs_data[4:0]; end
          6'h06: begin dec.alu_ctrl = 4'b1000; dec.shamt = bus.id_rs_data[4:0]; end
`else
          6'h04, 6'h06: dec.illegal = 1'b1;
`endif
          default: dec.illegal = 1'b1;
        endcase
      end
      6'h08: begin dec.src_b = imm_sext; dec.ovf_chk = 1'b1; end
      6'h09: dec.src_b = imm_sext;
      6'h0A: begin dec.alu_ctrl = 4'b0110; dec.src_b = imm_sext; end
      6'h0B: begin dec.alu_ctrl = 4'b0111; dec.src_b = imm_sext; end
      6'h0C: begin dec.alu_ctrl = 4'b0010; dec.src_b = imm_zext; end
      6'h0D: begin dec.alu_ctrl = 4'b0011; dec.src_b = imm_zext; end
      6'h0E: begin dec.alu_ctrl = 4'b0100; dec.src_b = imm_zext; end
      6'h0F: begin
        dec.alu_ctrl = 4'b1001;
        dec.src_b    = imm_zext;
        dec.shamt    = 5'(LUI_SHAMT);
      end
      6'h23, 6'h2B: dec.src_b = imm_sext;
      6'h04, 6'h05: dec.alu_ctrl = 4'b0001;
      default: dec.illegal = 1'b1;
    endcase
  end

  // id_ready only depends on skid occupancy, so it is a pure flop output.
  assign accept    = bus.id_valid & ~skid_valid_reg;
  assign drain     = main_valid_reg & bus.ex_ready;
  assign load_main = ~main_valid_reg | drain;

  // Two-entry FIFO: main feeds EX, skid catches the beat accepted while main stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      main_reg       <= '0;
      skid_reg       <= '0;
    end else if (bus.flush) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else begin
      if (load_main) begin
        if (skid_valid_reg) begin
          main_reg       <= skid_reg;
          main_valid_reg <= 1'b1;
        end else if (accept) begin
          main_reg       <= dec;
          main_valid_reg <= 1'b1;
        end else begin
          main_valid_reg <= 1'b0;
        end
      end
      if (accept && !load_main) begin
        skid_reg       <= dec;
        skid_valid_reg <= 1'b1;
      end else if (skid_valid_reg && load_main) begin
        skid_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.id_ready    = ~skid_valid_reg;
  assign bus.ex_valid    = main_valid_reg;
  assign bus.ex_alu_ctrl = main_reg.alu_ctrl;
  assign bus.ex_shamt    = main_reg.shamt;
  assign bus.ex_src_a    = main_reg.src_a;
  assign bus.ex_src_b    = main_reg.src_b;
  assign bus.ex_ovf_chk  = main_reg.ovf_chk;
  assign bus.ex_illegal  = main_reg.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: scoreboard bench for alu_issue_stage. Accepted beats are
// pushed as expected entries by the driver; a monitor pops and compares them
// whenever EX sees a valid entry. Honours ALU_ISSUE_SHIFTV_EN in the model.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
    logic        ovf;
    logic        ill;
  } exp_t;

  typedef enum {
    M_ADD, M_ADDU, M_SUB, M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU,
    M_SLL, M_SRL, M_SLLV, M_SRLV, M_ADDI, M_ADDIU, M_SLTI, M_SLTIU, M_ANDI,
    M_ORI, M_XORI, M_LUI, M_LW, M_SW, M_BEQ, M_BNE, M_BAD
  } mn_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  alu_issue_if #(.DATA_W(32)) bus ();

  alu_issue_stage #(.DATA_W(32), .LUI_SHAMT(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Name the instruction first, then derive its ALU view from the name.
  function automatic mn_t mnemonic(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'h00) begin
      case (fn)
        6'h20: return M_ADD;   6'h21: return M_ADDU;
        6'h22: return M_SUB;   6'h23: return M_SUBU;
        6'h24: return M_AND;   6'h25: return M_OR;
        6'h26: return M_XOR;   6'h27: return M_NOR;
        6'h2A: return M_SLT;   6'h2B: return M_SLTU;
        6'h00: return M_SLL;   6'h02: return M_SRL;
`ifdef ALU_ISSUE_SHIFTV_EN
        6'h04: return M_SLLV;  6'h06: return M_SRLV;
`endif
        default: return M_BAD;
      endcase
    end
    case (op)
      6'h08: return M_ADDI;  6'h09: return M_ADDIU;
      6'h0A: return M_SLTI;  6'h0B: return M_SLTIU;
      6'h0C: return M_ANDI;  6'h0D: return M_ORI;
      6'h0E: return M_XORI;  6'h0F: return M_LUI;
      6'h23: return M_LW;    6'h2B: return M_SW;
      6'h04: return M_BEQ;   6'h05: return M_BNE;
      default: return M_BAD;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    exp_t        e;
    mn_t         m;
    int unsigned imm;
    int          simm;
    m    = mnemonic(ins);
    imm  = int'(ins[15:0]);
    simm = int'($signed(ins[15:0]));
    e.a  = rs;
    case (m)
      M_ADDI, M_ADDIU, M_SLTI, M_SLTIU, M_LW, M_SW: e.b = 32'(simm);
      M_ANDI, M_ORI, M_XORI, M_LUI:                 e.b = 32'(imm);
      default:                                      e.b = rt;
    endcase
    case (m)
      M_SUB, M_SUBU, M_BEQ, M_BNE:  e.ctrl = 4'd1;
      M_AND, M_ANDI:                e.ctrl = 4'd2;
      M_OR, M_ORI:                  e.ctrl = 4'd3;
      M_XOR, M_XORI:                e.ctrl = 4'd4;
      M_NOR:                        e.ctrl = 4'd5;
      M_SLT, M_SLTI:                e.ctrl = 4'd6;
      M_SLTU, M_SLTIU:              e.ctrl = 4'd7;
      M_SRL, M_SRLV:                e.ctrl = 4'd8;
      M_SLL, M_SLLV, M_LUI:         e.ctrl = 4'd9;
      default:                      e.ctrl = 4'd0;
    endcase
    case (m)
      M_SLL, M_SRL:   e.shamt = ins[10:6];
      M_SLLV, M_SRLV: e.shamt = rs[4:0];
      M_LUI:          e.shamt = 5'd16;
      default:        e.shamt = 5'd0;
    endcase
    e.ovf = (m == M_ADD || m == M_SUB || m == M_ADDI);
    e.ill = (m == M_BAD);
    return e;
  endfunction

  function automatic exp_t actual();
    return exp_t'({bus.ex_alu_ctrl, bus.ex_shamt, bus.ex_src_a, bus.ex_src_b,
                   bus.ex_ovf_chk, bus.ex_illegal});
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: compare the presented EX entry with the oldest expected one; pop on transfer.
  always @(negedge clk) begin
    if (rst_n && !bus.flush && bus.ex_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ex_valid", 80'(bus.ex_valid), 80'(0));
      end else begin
        check("sb_entry", 80'(actual()), 80'(sb_q[0]));
        if (bus.ex_ready) begin
          $display("[TB] t=%0t out ctrl=%h shamt=%0d a=%h b=%h ovf=%b ill=%b",
                   $time, bus.ex_alu_ctrl, bus.ex_shamt, bus.ex_src_a,
                   bus.ex_src_b, bus.ex_ovf_chk, bus.ex_illegal);
          void'(sb_q.pop_front());
        end
      end
    end
  end

  // One cycle of stimulus; records accepts and flushes in the scoreboard.
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                       input logic [31:0] rt, input logic rdy, input logic fl,
                       output logic acc);
    @(posedge clk);
    #1;
    bus.id_valid   = v;
    bus.id_instr   = ins;
    bus.id_rs_data = rs;
    bus.id_rt_data = rt;
    bus.ex_ready   = rdy;
    bus.flush      = fl;
    @(negedge clk);
    #1;
    acc = 1'b0;
    if (bus.flush) begin
      sb_q.delete();
    end else if (bus.id_valid && bus.id_ready) begin
      acc = 1'b1;
      sb_q.push_back(model(ins, rs, rt));
    end
  endtask

  task automatic idle(input logic rdy);
    logic acc;
    drive(1'b0, 32'h0, 32'h0, 32'h0, rdy, 1'b0, acc);
  endtask

  // Hold a beat until accepted, with a bounded wait.
  task automatic send(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                      input logic rdy);
    logic acc;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) drive(1'b1, ins, rs, rt, rdy, 1'b0, acc);
    if (!acc) check("send_timeout", 80'(acc), 80'(1));
  endtask

  // Issue one beat with EX ready and check the next cycle's outputs against constants.
  task automatic directed(input string name, input logic [31:0] ins, input logic [31:0] rs,
                          input logic [31:0] rt, input exp_t req);
    send(ins, rs, rt, 1'b1);
    idle(1'b1);
    check({name, "_valid"}, 80'(bus.ex_valid), 80'(1));
    check(name, 80'(actual()), 80'(req));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] r_fn[14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                             6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h04, 6'h06};
    logic [5:0] i_op[12] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                             6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05};
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 2))
      0:       return {6'h00, w[25:6], r_fn[$urandom_range(0, 13)]};
      1:       return {i_op[$urandom_range(0, 11)], w[25:0]};
      default: return w;
    endcase
  endfunction

  initial begin
    logic acc;
    exp_t e;
    bus.flush      = 1'b0;
    bus.id_valid   = 1'b1;
    bus.id_instr   = 32'h00221820;
    bus.id_rs_data = 32'd5;
    bus.id_rt_data = 32'd7;
    bus.ex_ready   = 1'b1;

    // Reset held with id_valid high: nothing may enter.
    repeat (3) @(negedge clk);
    check("reset_ex_valid", 80'(bus.ex_valid), 80'(0));
    check("reset_id_ready", 80'(bus.id_ready), 80'(1));
    check("reset_fields", 80'(actual()), 80'(0));
    @(posedge clk);
    #1;
    bus.id_valid = 1'b0;
    rst_n        = 1'b1;

    // Directed decode cases.
    directed("add",  32'h00221820, 32'd5, 32'd7, exp_t'({4'd0, 5'd0, 32'd5, 32'd7, 1'b1, 1'b0}));
    directed("addi", 32'h2001FFFF, 32'h10, 32'h99, exp_t'({4'd0, 5'd0, 32'h10, 32'hFFFFFFFF, 1'b1, 1'b0}));
    directed("ori",  32'h3401FFFF, 32'h10, 32'h99, exp_t'({4'd3, 5'd0, 32'h10, 32'h0000FFFF, 1'b0, 1'b0}));
    directed("lui",  32'h3C011234, 32'h10, 32'h99, exp_t'({4'd9, 5'd16, 32'h10, 32'h00001234, 1'b0, 1'b0}));
`ifdef ALU_ISSUE_SHIFTV_EN
    directed("sllv", 32'h00221804, 32'h23, 32'h77, exp_t'({4'd9, 5'd3, 32'h23, 32'h77, 1'b0, 1'b0}));
`else
    directed("sllv", 32'h00221804, 32'h23, 32'h77, exp_t'({4'd0, 5'd0, 32'h23, 32'h77, 1'b0, 1'b1}));
`endif
    idle(1'b1);

    // Back-to-back beats with EX stalled: two fit, the third waits.
    drive(1'b1, 32'h00221822, 32'd100, 32'd1, 1'b0, 1'b0, acc);
    check("b2b_first_acc", 80'(acc), 80'(1));
    drive(1'b1, 32'h00221824, 32'hF0F0, 32'h0FF0, 1'b0, 1'b0, acc);
    check("b2b_second_acc", 80'(acc), 80'(1));
    drive(1'b1, 32'h00221825, 32'h1, 32'h2, 1'b0, 1'b0, acc);
    check("b2b_third_blocked", 80'(bus.id_ready), 80'(0));
    send(32'h00221825, 32'h1, 32'h2, 1'b1);
    repeat (4) idle(1'b1);
    check("b2b_none_lost", 80'(sb_q.size()), 80'(0));

    // Flush with both entries full and a beat offered in the same cycle.
    drive(1'b1, 32'h00221826, 32'hA, 32'hB, 1'b0, 1'b0, acc);
    drive(1'b1, 32'h00221827, 32'hC, 32'hD, 1'b0, 1'b0, acc);
    drive(1'b1, 32'h0022182A, 32'hE, 32'hF, 1'b0, 1'b1, acc);
    idle(1'b1);
    check("flush_ex_valid", 80'(bus.ex_valid), 80'(0));
    check("flush_id_ready", 80'(bus.id_ready), 80'(1));
    repeat (3) idle(1'b1);
    check("flush_empty", 80'(sb_q.size()), 80'(0));

    // Randomised traffic with random backpressure and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      ins = rand_instr();
      drive($urandom_range(0, 3) != 0, ins, $urandom, $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, acc);
      if (acc) begin
        e = model(ins, bus.id_rs_data, bus.id_rt_data);
        $display("[TB] t=%0t in instr=%h exp ctrl=%h shamt=%0d ill=%b",
                 $time, ins, e.ctrl, e.shamt, e.ill);
      end
    end
    repeat (5) idle(1'b1);
    check("random_drained", 80'(sb_q.size()), 80'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
